// File: rtl/fft_8p_frame_buf_if.sv
// fft_8p_frame_buf_if: sample stream in, parallel frame out, for the FFT input stage
interface fft_8p_frame_buf_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N = 8
);
  logic s_valid, s_ready, s_last;
  logic signed [DATA_WIDTH-1:0] s_real, s_imag;
  logic m_valid, m_ready;
  logic signed [DATA_WIDTH-1:0] m_real [N-1:0];
  logic signed [DATA_WIDTH-1:0] m_imag [N-1:0];
  modport master (
    output s_valid, s_real, s_imag, s_last, m_ready,
    input  s_ready, m_valid, m_real, m_imag
  );
  modport slave (
    input  s_valid, s_real, s_imag, s_last, m_ready,
    output s_ready, m_valid, m_real, m_imag
  );
endinterface

// File: rtl/fft_8p_frame_buf.sv
// fft_8p_frame_buf: ping-pong frame collector, optional bit-reversed storage
module fft_8p_frame_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int N = 8,
  parameter int BIT_REV = 1
) (
  input  logic clk,
  input  logic rst,
  fft_8p_frame_buf_if.slave bus_io,
  output logic frame_err_o,
  output logic [15:0] frame_cnt_o
);
  localparam int AW = $clog2(N);
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] x);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = x[AW-1-i];
    return r;
  endfunction
  logic signed [DATA_WIDTH-1:0] re_q [1:0][N-1:0];
  logic signed [DATA_WIDTH-1:0] im_q [1:0][N-1:0];
  logic [1:0] full_q, full_d;
  logic wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d, err_q, err_d;
  logic [AW-1:0] wr_idx_q, wr_idx_d, waddr;
  logic [15:0] cnt_q, cnt_d;
  logic acc, rd, last_idx, good;
  assign bus_io.s_ready = !rst && !full_q[wr_sel_q];
  assign bus_io.m_valid = full_q[rd_sel_q];
  assign bus_io.m_real = re_q[rd_sel_q];
  assign bus_io.m_imag = im_q[rd_sel_q];
  assign frame_err_o = err_q;
  assign frame_cnt_o = cnt_q;
  assign acc = bus_io.s_valid && bus_io.s_ready;
  assign rd = bus_io.m_valid && bus_io.m_ready;
  assign last_idx = wr_idx_q == AW'(N - 1);
  assign good = acc && last_idx && bus_io.s_last;
  assign waddr = (BIT_REV != 0) ? bitrev(wr_idx_q) : wr_idx_q;
  // write and release never hit the same bank: writes need an EMPTY bank, releases a FULL one
  always_comb begin
    full_d = full_q;
    if (good) full_d[wr_sel_q] = 1'b1;
    if (rd) full_d[rd_sel_q] = 1'b0;
    wr_sel_d = wr_sel_q ^ good;
    rd_sel_d = rd_sel_q ^ rd;
    wr_idx_d = !acc ? wr_idx_q : (last_idx || bus_io.s_last) ? '0 : wr_idx_q + AW'(1);
    err_d = acc && (bus_io.s_last != last_idx);
    cnt_d = cnt_q + 16'(rd);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_idx_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      full_q <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_idx_q <= wr_idx_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < N; i++) begin
          re_q[b][i] <= '0;
          im_q[b][i] <= '0;
        end
    end else if (acc) begin
      re_q[wr_sel_q][waddr] <= bus_io.s_real;
      im_q[wr_sel_q][waddr] <= bus_io.s_imag;
    end
  end
endmodule

// File: tb/tb_fft_8p_frame_buf.sv
// tb_fft_8p_frame_buf: directed checks on a BIT_REV=1 and a BIT_REV=0 instance fed the same stream
module tb_fft_8p_frame_buf;
  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [15:0] s_real = '0, s_imag = '0;
  logic err1, err0;
  logic [15:0] cnt1, cnt0;
  int cmp = 0, bad = 0;
  logic [15:0] er [8];
  logic [15:0] ei [8];
  int br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int exp1 [8] = '{0, 1024, 512, 1536, 256, 1280, 768, 1792};
  fft_8p_frame_buf_if #(.DATA_WIDTH(16), .N(8)) b1 ();
  fft_8p_frame_buf_if #(.DATA_WIDTH(16), .N(8)) b0 ();
  assign b1.s_valid = s_valid;
  assign b1.s_last = s_last;
  assign b1.s_real = s_real;
  assign b1.s_imag = s_imag;
  assign b1.m_ready = m_ready;
  assign b0.s_valid = s_valid;
  assign b0.s_last = s_last;
  assign b0.s_real = s_real;
  assign b0.s_imag = s_imag;
  assign b0.m_ready = m_ready;
  fft_8p_frame_buf #(.DATA_WIDTH(16), .N(8), .BIT_REV(1)) dut1 (
    .clk(clk), .rst(rst), .bus_io(b1), .frame_err_o(err1), .frame_cnt_o(cnt1)
  );
  fft_8p_frame_buf #(.DATA_WIDTH(16), .N(8), .BIT_REV(0)) dut0 (
    .clk(clk), .rst(rst), .bus_io(b0), .frame_err_o(err0), .frame_cnt_o(cnt0)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load(int f);
    for (int k = 0; k < 8; k++) begin
      er[k] = 16'(f * 4099 + k * 517);
      ei[k] = 16'(16'h8000 ^ (f * 31 + k * 1000));
    end
  endtask
  task automatic push(logic [15:0] re, logic [15:0] im, logic last);
    logic ok = 1'b0;
    s_valid = 1'b1;
    s_real = re;
    s_imag = im;
    s_last = last;
    for (int t = 0; t < 40 && !ok; t++) begin
      ok = b1.s_ready;
      tick();
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    chk("push_accepted", 16'(ok), 16'd1);
  endtask
  task automatic send_frame(int f);
    load(f);
    for (int k = 0; k < 8; k++) push(er[k], ei[k], k == 7);
  endtask
  task automatic check_frame(string tag, int f);
    load(f);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_re_rev"}, b1.m_real[i], er[br[i]]);
      chk({tag, "_im_rev"}, b1.m_imag[i], ei[br[i]]);
      chk({tag, "_re_lin"}, b0.m_real[i], er[i]);
      chk({tag, "_im_lin"}, b0.m_imag[i], ei[i]);
    end
  endtask
  task automatic status(string tag, logic mv, logic sr, logic fe, logic [15:0] fc);
    chk({tag, "_mvalid_rev"}, 16'(b1.m_valid), 16'(mv));
    chk({tag, "_mvalid_lin"}, 16'(b0.m_valid), 16'(mv));
    chk({tag, "_sready_rev"}, 16'(b1.s_ready), 16'(sr));
    chk({tag, "_sready_lin"}, 16'(b0.s_ready), 16'(sr));
    chk({tag, "_err_rev"}, 16'(err1), 16'(fe));
    chk({tag, "_err_lin"}, 16'(err0), 16'(fe));
    chk({tag, "_cnt_rev"}, cnt1, fc);
    chk({tag, "_cnt_lin"}, cnt0, fc);
  endtask
  task automatic consume();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    status("reset", 1'b0, 1'b0, 1'b0, 16'd0);
    chk("reset_data", b1.m_real[3], 16'd0);
    rst = 1'b0;
    tick();
    status("post_reset", 1'b0, 1'b1, 1'b0, 16'd0);
    for (int k = 0; k < 7; k++) push(16'(k * 256), 16'd256, 1'b0);
    status("seven_in", 1'b0, 1'b1, 1'b0, 16'd0);
    push(16'(7 * 256), 16'd256, 1'b1);
    status("first_frame", 1'b1, 1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 8; i++) begin
      chk("ff_re_rev", b1.m_real[i], 16'(exp1[i]));
      chk("ff_re_lin", b0.m_real[i], 16'(i * 256));
      chk("ff_im_rev", b1.m_imag[i], 16'd256);
      chk("ff_im_lin", b0.m_imag[i], 16'd256);
    end
    consume();
    status("first_consumed", 1'b0, 1'b1, 1'b0, 16'd1);
    send_frame(1);
    send_frame(2);
    status("both_full", 1'b1, 1'b0, 1'b0, 16'd1);
    check_frame("bp_f1", 1);
    load(3);
    s_valid = 1'b1;
    s_real = er[0];
    s_imag = ei[0];
    tick();
    tick();
    status("stalled", 1'b1, 1'b0, 1'b0, 16'd1);
    check_frame("bp_f1_held", 1);
    consume();
    status("bp_release", 1'b1, 1'b1, 1'b0, 16'd2);
    check_frame("bp_f2", 2);
    s_valid = 1'b0;
    send_frame(3);
    status("f3_in", 1'b1, 1'b0, 1'b0, 16'd2);
    consume();
    status("f2_gone", 1'b1, 1'b1, 1'b0, 16'd3);
    check_frame("bp_f3", 3);
    consume();
    status("f3_gone", 1'b0, 1'b1, 1'b0, 16'd4);
    load(4);
    for (int k = 0; k < 5; k++) push(er[k], ei[k], k == 4);
    status("early_last", 1'b0, 1'b1, 1'b1, 16'd4);
    tick();
    status("early_last_next", 1'b0, 1'b1, 1'b0, 16'd4);
    send_frame(5);
    status("recover1", 1'b1, 1'b1, 1'b0, 16'd4);
    check_frame("recover1", 5);
    consume();
    load(6);
    for (int k = 0; k < 8; k++) push(er[k], ei[k], 1'b0);
    status("missing_last", 1'b0, 1'b1, 1'b1, 16'd5);
    tick();
    status("missing_last_next", 1'b0, 1'b1, 1'b0, 16'd5);
    send_frame(7);
    status("recover2", 1'b1, 1'b1, 1'b0, 16'd5);
    check_frame("recover2", 7);
    consume();
    status("recover2_gone", 1'b0, 1'b1, 1'b0, 16'd6);
    m_ready = 1'b1;
    for (int f = 0; f < 100; f++) begin
      load(100 + f);
      for (int k = 0; k < 8; k++) begin
        chk("stream_ready", 16'(b1.s_ready), 16'd1);
        push(er[k], ei[k], k == 7);
      end
      status("stream", 1'b1, 1'b1, 1'b0, 16'(6 + f));
      check_frame("stream", 100 + f);
    end
    tick();
    m_ready = 1'b0;
    status("stream_end", 1'b0, 1'b1, 1'b0, 16'd106);
    load(200);
    for (int k = 0; k < 4; k++) push(er[k], ei[k], 1'b0);
    rst = 1'b1;
    s_valid = 1'b1;
    s_real = er[4];
    s_imag = ei[4];
    #1;
    chk("rst_sready_comb", 16'(b1.s_ready), 16'd0);
    tick();
    status("mid_rst", 1'b0, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 8; i++) begin
      chk("mid_rst_re", b1.m_real[i], 16'd0);
      chk("mid_rst_im", b0.m_imag[i], 16'd0);
    end
    rst = 1'b0;
    s_valid = 1'b0;
    tick();
    status("after_rst", 1'b0, 1'b1, 1'b0, 16'd0);
    send_frame(201);
    status("after_rst_frame", 1'b1, 1'b1, 1'b0, 16'd0);
    check_frame("after_rst", 201);
    consume();
    status("after_rst_gone", 1'b0, 1'b1, 1'b0, 16'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
